// File: rtl/drp_wb.sv
// rtl/drp_wb.sv - DRP responder replaying each access as one classic Wishbone master cycle (optional timeout: DRP_WB_TIMEOUT_EN)
module drp_wb #(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] drp_addr,
    input  logic [15:0]           drp_di,
    output logic [15:0]           drp_do,
    input  logic                  drp_en,
    input  logic                  drp_we,
    output logic                  drp_rdy,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    input  logic [15:0]           wb_dat_i,
    output logic [15:0]           wb_dat_o,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic                  wb_cyc_o
`ifdef DRP_WB_TIMEOUT_EN
    ,
    output logic                  drp_timeout
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_n;
    logic   accept;
    logic   done;
    logic   fail;
    logic   tmo_hit;

`ifdef DRP_WB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;
`else
    logic [15:0] tmo_param_unused;
    assign tmo_param_unused = 16'(TIMEOUT);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and termination decode; err wins over ack, timeout only when neither arrives
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        fail    = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            IDLE: begin
                if (drp_en) begin
                    accept  = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (wb_err_i) begin
                    done = 1'b1;
                    fail = 1'b1;
                end else if (wb_ack_i) begin
                    done = 1'b1;
`ifdef DRP_WB_TIMEOUT_EN
                end else if (tmo_cnt == TMO_LAST) begin
                    done    = 1'b1;
                    fail    = 1'b1;
                    tmo_hit = 1'b1;
`endif
                end
                if (done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered Wishbone request and DRP response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            drp_do   <= '0;
            drp_rdy  <= 1'b0;
        end else begin
            drp_rdy <= done;
            if (accept) begin
                wb_adr_o <= drp_addr;
                wb_dat_o <= drp_di;
                wb_we_o  <= drp_we;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end else if (done) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
            end
            if (done && !wb_we_o) begin
                drp_do <= fail ? 16'h0000 : wb_dat_i;
            end
        end
    end

`ifdef DRP_WB_TIMEOUT_EN
    // Timeout counter: cleared on entry to BUSY, counts each BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            drp_timeout <= 1'b0;
        end else begin
            drp_timeout <= tmo_hit;
            if (accept) begin
                tmo_cnt <= '0;
            end else if (state == BUSY) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_drp_wb.sv
// tb/tb_drp_wb.sv - directed self-checking bench for drp_wb
module tb_drp_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] drp_addr = '0;
    logic [15:0] drp_di = '0;
    logic [15:0] drp_do;
    logic        drp_en = 1'b0;
    logic        drp_we = 1'b0;
    logic        drp_rdy;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_cyc_o;
`ifdef DRP_WB_TIMEOUT_EN
    logic        drp_timeout;
`endif

    int errors = 0;
    int checks = 0;
    int rdy_cnt = 0;
    int cyc_starts = 0;
    logic cyc_prev = 1'b0;

    drp_wb #(.ADDR_WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .drp_addr(drp_addr), .drp_di(drp_di), .drp_do(drp_do),
        .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(drp_rdy),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_cyc_o(wb_cyc_o)
`ifdef DRP_WB_TIMEOUT_EN
        , .drp_timeout(drp_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Count completion pulses and Wishbone cycle starts
    always @(negedge clk) begin
        if (drp_rdy) rdy_cnt++;
        if (wb_cyc_o && !cyc_prev) cyc_starts++;
        cyc_prev = wb_cyc_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drp_req(input logic [15:0] a, input logic [15:0] d, input logic we);
        drp_en = 1'b1; drp_addr = a; drp_di = d; drp_we = we;
        step();
        drp_en = 1'b0;
    endtask

    initial begin
        int r0, c0, n;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_do", drp_do, 0);
        check("rst_rdy", drp_rdy, 0);

        // ack while idle is ignored
        wb_ack_i = 1'b1; wb_dat_i = 16'h1357;
        step();
        wb_ack_i = 1'b0;
        check("idle_ack_rdy", drp_rdy, 0);
        check("idle_ack_cyc", wb_cyc_o, 0);

        // read, zero wait
        drp_req(16'h0042, 16'h0000, 1'b0);
        check("rd0_cyc", wb_cyc_o, 1);
        check("rd0_stb", wb_stb_o, 1);
        check("rd0_adr", wb_adr_o, 16'h0042);
        check("rd0_rdy_early", drp_rdy, 0);
        wb_ack_i = 1'b1; wb_dat_i = 16'hA5C3;
        step();
        wb_ack_i = 1'b0;
        check("rd0_rdy", drp_rdy, 1);
        check("rd0_cyc_low", wb_cyc_o, 0);
        check("rd0_do", drp_do, 16'hA5C3);
        step();
        check("rd0_rdy_pulse", drp_rdy, 0);
        check("rd0_do_hold", drp_do, 16'hA5C3);

        // write, 3 wait states
        r0 = rdy_cnt;
        drp_req(16'h0010, 16'h1234, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("wr_we", wb_we_o, 1);
            check("wr_dat", wb_dat_o, 16'h1234);
            check("wr_cyc", wb_cyc_o, 1);
            check("wr_rdy_wait", drp_rdy, 0);
            step();
        end
        check("wr_dat4", wb_dat_o, 16'h1234);
        check("wr_adr", wb_adr_o, 16'h0010);
        wb_ack_i = 1'b1; wb_dat_i = 16'hFFFF;
        step();
        wb_ack_i = 1'b0;
        check("wr_rdy", drp_rdy, 1);
        check("wr_cyc_low", wb_cyc_o, 0);
        check("wr_do_unch", drp_do, 16'hA5C3);
        step();
        check("wr_rdy_count", rdy_cnt - r0, 1);

        // error: ack and err together on a read
        r0 = rdy_cnt;
        drp_req(16'h0020, 16'h0000, 1'b0);
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 16'hBEEF;
        step();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check("err_rdy", drp_rdy, 1);
        check("err_do", drp_do, 16'h0000);
        step();
        check("err_rdy_count", rdy_cnt - r0, 1);

        // protocol violation: drp_en while busy
        r0 = rdy_cnt; c0 = cyc_starts;
        drp_req(16'h0030, 16'h0000, 1'b0);
        drp_req(16'h0099, 16'h0000, 1'b0);
        check("viol_adr", wb_adr_o, 16'h0030);
        check("viol_cyc", wb_cyc_o, 1);
        wb_ack_i = 1'b1; wb_dat_i = 16'h1111;
        step();
        wb_ack_i = 1'b0;
        check("viol_do", drp_do, 16'h1111);
        step(); step();
        check("viol_rdy_count", rdy_cnt - r0, 1);
        check("viol_cyc_count", cyc_starts - c0, 1);
        check("viol_idle", wb_cyc_o, 0);

        // reset in the second busy cycle
        r0 = rdy_cnt;
        drp_req(16'h0050, 16'h0000, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_cyc", wb_cyc_o, 0);
        check("rstmid_stb", wb_stb_o, 0);
        check("rstmid_rdy", drp_rdy, 0);
        step();
        check("rstmid_rdy_count", rdy_cnt - r0, 0);
        drp_req(16'h0001, 16'h0000, 1'b0);
        check("rstmid_rd_adr", wb_adr_o, 16'h0001);
        wb_ack_i = 1'b1; wb_dat_i = 16'h7E7E;
        step();
        wb_ack_i = 1'b0;
        check("rstmid_rd_rdy", drp_rdy, 1);
        check("rstmid_rd_do", drp_do, 16'h7E7E);

        // back-to-back: drp_en in the drp_rdy cycle is accepted
        drp_req(16'h0060, 16'h5555, 1'b1);
        check("b2b_cyc", wb_cyc_o, 1);
        check("b2b_adr", wb_adr_o, 16'h0060);
        check("b2b_we", wb_we_o, 1);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        check("b2b_rdy", drp_rdy, 1);
        check("b2b_do", drp_do, 16'h7E7E);
        step();

`ifdef DRP_WB_TIMEOUT_EN
        // timeout with a slave that never answers
        drp_req(16'h0070, 16'h0000, 1'b0);
        n = 0;
        while (wb_cyc_o && n < 20) begin
            n++;
            step();
        end
        check("tmo_cyc_cycles", n, 8);
        check("tmo_rdy", drp_rdy, 1);
        check("tmo_flag", drp_timeout, 1);
        check("tmo_do", drp_do, 16'h0000);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        check("tmo_late_ack_rdy", drp_rdy, 0);
        check("tmo_flag_pulse", drp_timeout, 0);
`else
        n = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
